// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, tick-sampled debounce FSM and
// registered press/release strobes per channel. Define BTN_REPEAT_EN for auto-repeat.
module btn_debounce #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned TICK_DIV        = 125000,
  parameter int unsigned DEB_TICKS       = 20,
  parameter int unsigned REP_DELAY_TICKS = 500,
  parameter int unsigned REP_RATE_TICKS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             tick
);

  localparam int unsigned    PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]     CNT_LAST = 8'(DEB_TICKS - 1);

  typedef enum logic [1:0] {IDLE, ARMING, HELD, DISARM} state_t;

  logic [PW-1:0]    pre;
  logic [N_BTN-1:0] sync1, sync2;
  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [7:0]       cnt_q   [N_BTN];
  logic [7:0]       cnt_d   [N_BTN];
  logic [N_BTN-1:0] press_d, release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      tick  <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      if (pre == PRE_LAST) begin
        pre  <= '0;
        tick <= 1'b1;
      end else begin
        pre  <= pre + 1'b1;
        tick <= 1'b0;
      end
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [15:0] REP_DELAY  = 16'(REP_DELAY_TICKS);
  localparam logic [15:0] REP_RELOAD = 16'(REP_DELAY_TICKS - REP_RATE_TICKS);

  logic [15:0] rep_q [N_BTN];
  logic [15:0] rep_d [N_BTN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) rep_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) rep_q[i] <= rep_d[i];
    end
  end
`endif

  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef BTN_REPEAT_EN
      rep_d[i]   = rep_q[i];
`endif
      if (tick) begin
        unique case (state_q[i])
          IDLE: begin
            if (sync2[i]) begin
              state_d[i] = ARMING;
              cnt_d[i]   = 8'd1;
            end
          end
          ARMING: begin
            if (!sync2[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = HELD;
              cnt_d[i]   = '0;
              press_d[i] = 1'b1;
`ifdef BTN_REPEAT_EN
              rep_d[i]   = '0;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          HELD: begin
            if (!sync2[i]) begin
              state_d[i] = DISARM;
              cnt_d[i]   = 8'd1;
            end
`ifdef BTN_REPEAT_EN
            // Reload keeps the repeat counter in [DELAY-RATE, DELAY]; it resumes after a DISARM bounce.
            else if (rep_q[i] + 16'd1 == REP_DELAY) begin
              rep_d[i]   = REP_RELOAD;
              press_d[i] = 1'b1;
            end else begin
              rep_d[i] = rep_q[i] + 16'd1;
            end
`endif
          end
          DISARM: begin
            if (sync2[i]) begin
              state_d[i] = HELD;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i]   = IDLE;
              cnt_d[i]     = '0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Debounced level is exactly "FSM is on the pressed side".
  always_comb begin
    btn_level = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      btn_level[i] = (state_q[i] == HELD) || (state_q[i] == DISARM);
    end
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions the raw push-button inputs of the stopwatch and display boards before they reach counter or control logic.
- Per button:
  - 2-FF synchronizer
  - tick-sampled debounce FSM
  - registered, single-cycle press/release strobes that run on clk
- Downstream stopwatch control consumes btn_press as a clean start/stop and clear request; btn_level is for hold-sensitive logic.

Parameters:
N_BTN, 2, number of independent button channels
TICK_DIV, 125000, clk cycles per sample tick (legal range 2..2^24)
DEB_TICKS, 20, consecutive agreeing sample ticks required to change debounced state (legal range 2..255)
REP_DELAY_TICKS, 500, ticks held before first auto-repeat strobe (BTN_REPEAT_EN only)
REP_RATE_TICKS, 100, ticks between subsequent auto-repeat strobes (BTN_REPEAT_EN only)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
btn_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed
btn_level  output  N_BTN  debounced level per button
btn_press  output  N_BTN  1-cycle strobe on debounced press (and on auto-repeat when enabled)
btn_release  output  N_BTN  1-cycle strobe on debounced release
tick  output  1  sample-tick strobe, exposed for verification

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler=0; tick=0
  - synchronizer flops=0
  - every channel in IDLE, debounce counter=0
  - btn_level=0, btn_press=0, btn_release=0
  - Reset overrides all other activity, including mid-count and mid-HELD.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is registered and high for exactly one cycle per wrap: first tick TICK_DIV cycles after rst deasserts, then every TICK_DIV cycles.
- Synchronizer: s = btn_raw delayed 2 clk; all FSM decisions use s only.
- Per-channel FSM (evaluated only on cycles with tick=1; state is held otherwise):
  - IDLE: s=1 -> ARMING, cnt=1. s=0 -> stay.
  - ARMING:
    - s=0 -> IDLE, cnt=0 (bounce rejected).
    - s=1 and cnt==DEB_TICKS-1 -> HELD, cnt=0, btn_level<=1, btn_press<=1.
    - otherwise cnt+1.
  - HELD: s=0 -> DISARM, cnt=1. s=1 -> stay.
  - DISARM:
    - s=1 -> HELD, cnt=0 (no strobe).
    - s=0 and cnt==DEB_TICKS-1 -> IDLE, cnt=0, btn_level<=0, btn_release<=1.
    - otherwise cnt+1.
- Strobes are registered: high the cycle after the deciding tick edge, cleared on the next edge. They never exceed 1 cycle.
- Latency: a clean press becomes visible on btn_press after 2 sync cycles + DEB_TICKS ticks (plus up to one tick period of phase).
- Channels are fully independent. Simultaneous presses on several channels produce strobes in the same cycle.
- btn_press and btn_release are never both high on one channel in the same cycle.
- cnt is 8 bits wide and saturates by construction; it never wraps.
- Button held through reset: after rst drops, the channel starts in IDLE and must re-debounce. btn_press fires DEB_TICKS ticks later; no release strobe is generated.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Each channel has a 16-bit repeat counter, zeroed on entry to HELD and incremented on each tick while in HELD.
  - At count REP_DELAY_TICKS: extra btn_press strobe, counter reloads to REP_DELAY_TICKS-REP_RATE_TICKS.
  - Result: subsequent strobes every REP_RATE_TICKS ticks.
  - Counting freezes in DISARM and resumes if the FSM returns to HELD.
  - Repeat strobes never occur in the same cycle as btn_release.
- Undefined: no repeat counter logic; exactly one btn_press per debounced press.

Test Plan:
- Bench params: TICK_DIV=4, DEB_TICKS=3, REP_DELAY_TICKS=5, REP_RATE_TICKS=2, N_BTN=2.
- Reset check: hold rst 3 cycles with btn_raw=2'b11 -> all outputs 0 during reset. After release, tick first at cycle 4, then every 4. btn_press=2'b11 pulses exactly once after the 3rd qualifying tick; btn_level=2'b11 thereafter.
- Bounce rejection: btn_raw[0] high for 6 cycles (1-2 ticks), then low -> btn_press[0] and btn_level[0] stay 0 throughout.
- Clean press/release on ch1: btn_raw[1]=1 held 40 cycles -> one btn_press[1] pulse of width 1, btn_level[1]=1. Then btn_raw[1]=0 -> btn_release[1] pulses once about 3 ticks later, btn_level[1]=0.
- Release glitch: in HELD, drop btn_raw[0] for 1 tick then restore -> no btn_release, btn_level stays 1, no extra btn_press.
- Mid-operation reset: assert rst while ch0 is in ARMING with cnt=2 -> next cycle all outputs 0. A continuing press needs a full 3 new ticks before btn_press.
- BTN_REPEAT_EN: hold ch0 for 30 ticks -> initial press strobe, then strobes at 5, 7, 9, ... ticks after entering HELD. Without the macro -> exactly 1 strobe.
